// File: rtl/dm_pipe_port_pkg.sv
// Shared constants for the pipelined data memory port: access type codes,
// device window defaults, exception causes and byte-lane helpers.
package dm_pipe_port_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'd0,
    DM_H  = 3'd1,
    DM_HU = 3'd2,
    DM_B  = 3'd3,
    DM_BU = 3'd4
  } dm_type_e;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5
  } dm_exc_e;

  localparam logic [31:0] DM_MMIO_BASE = 32'h0000_7f00;
  localparam logic [31:0] DM_MMIO_LAST = 32'h0000_7f1b;
  localparam logic [31:0] DM_RO_MASK   = 32'h0000_7f08;

  function automatic logic [31:0] dm_load_ext(input logic [31:0] word,
                                              input logic [2:0]  acc_type,
                                              input logic [1:0]  lo);
    logic [31:0] h_sh;
    logic [31:0] b_sh;
    logic [31:0] r;
    h_sh = word >> {lo[1], 4'b0000};
    b_sh = word >> {lo, 3'b000};
    r    = word;
    case (acc_type)
      DM_H:    r = {{16{h_sh[15]}}, h_sh[15:0]};
      DM_HU:   r = {16'h0000, h_sh[15:0]};
      DM_B:    r = {{24{b_sh[7]}}, b_sh[7:0]};
      DM_BU:   r = {24'h00_0000, b_sh[7:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Store merge: hu/bu codes write like h/b, anything else is a full word.
  function automatic logic [31:0] dm_store_merge(input logic [31:0] old,
                                                 input logic [31:0] wdata,
                                                 input logic [2:0]  acc_type,
                                                 input logic [1:0]  lo);
    logic [31:0] mask;
    logic [31:0] data;
    case (acc_type)
      DM_H, DM_HU: begin
        mask = 32'h0000_ffff << {lo[1], 4'b0000};
        data = {16'h0000, wdata[15:0]} << {lo[1], 4'b0000};
      end
      DM_B, DM_BU: begin
        mask = 32'h0000_00ff << {lo, 3'b000};
        data = {24'h00_0000, wdata[7:0]} << {lo, 3'b000};
      end
      default: begin
        mask = 32'hffff_ffff;
        data = wdata;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/dm_exc_check.sv
// Combinational AdEL/AdES detector for data accesses (alignment, range,
// device-window type and read-only registers); shared with the bridge.
module dm_exc_check
  import dm_pipe_port_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] MMIO_BASE   = DM_MMIO_BASE,
  parameter logic [31:0] MMIO_LAST   = DM_MMIO_LAST,
  parameter logic [31:0] RO_MASK     = DM_RO_MASK
) (
  input  logic [31:0] addr,
  input  logic [2:0]  acc_type,
  input  logic        we,
  input  logic        ov,
  output logic        adel,
  output logic        ades,
  output logic        ram_hit
);

  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic align_s, in_ram_s, in_mmio_s, range_s, devtype_s, ro_s, common_s;

  // Exception classification from the raw request fields
  always_comb begin
    case (acc_type)
      DM_W:        align_s = (addr[1:0] != 2'b00);
      DM_H, DM_HU: align_s = addr[0];
      default:     align_s = 1'b0;
    endcase
    in_ram_s  = (addr < RAM_BYTES);
    in_mmio_s = (addr >= MMIO_BASE) && (addr <= MMIO_LAST);
    range_s   = !in_ram_s && !in_mmio_s;
    devtype_s = (addr >= MMIO_BASE) && (acc_type != DM_W);
    ro_s      = (({addr[31:2], 2'b00} & ~32'h0000_0010) == RO_MASK);
    common_s  = align_s || range_s || devtype_s || ov;
    adel      = !we && common_s;
    ades      = we && (common_s || ro_s);
    ram_hit   = in_ram_s && !in_mmio_s;
  end

endmodule

// File: rtl/dm_pipe_port.sv
// Word-organised data RAM behind a valid/ready request port with a
// LATENCY-deep response pipeline that stalls under response backpressure.
module dm_pipe_port
  import dm_pipe_port_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] MMIO_BASE   = DM_MMIO_BASE,
  parameter logic [31:0] MMIO_LAST   = DM_MMIO_LAST,
  parameter logic [31:0] RO_MASK     = DM_RO_MASK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic        req_ov,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [31:0] resp_pc,
  output logic        resp_adel,
  output logic        resp_ades
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] ram_r [DEPTH_WORDS];

  logic [LATENCY-1:0] v_s, adel_v_s, ades_v_s, en_s;
  logic [31:0]        pc_s   [LATENCY];
  logic [31:0]        data_s [LATENCY];

  logic          exc_adel_s, exc_ades_s, ram_hit_s;
  logic          accept_s, wr_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   ram_word_s, ld_data_s;

  dm_exc_check #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .MMIO_BASE   (MMIO_BASE),
    .MMIO_LAST   (MMIO_LAST),
    .RO_MASK     (RO_MASK)
  ) u_exc (
    .addr     (req_addr),
    .acc_type (req_type),
    .we       (req_we),
    .ov       (req_ov),
    .adel     (exc_adel_s),
    .ades     (exc_ades_s),
    .ram_hit  (ram_hit_s)
  );

  assign idx_s      = req_addr[AW+1:2];
  assign ram_word_s = ram_r[idx_s];
  assign req_ready  = en_s[0];

  // Handshake, RAM write enable and the extended load value entering S1
  always_comb begin
    accept_s = req_valid && en_s[0];
    wr_s     = accept_s && req_we && !exc_ades_s && ram_hit_s;
    if (accept_s && !req_we && !exc_adel_s && ram_hit_s) begin
      ld_data_s = dm_load_ext(ram_word_s, req_type, req_addr[1:0]);
    end else begin
      ld_data_s = 32'h0000_0000;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      ram_r[idx_s] <= dm_store_merge(ram_word_s, req_wdata, req_type, req_addr[1:0]);
    end
  end

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic        v_r, adel_r, ades_r;
    logic [31:0] pc_r, data_r;
    logic        in_v_s, in_adel_s, in_ades_s;
    logic [31:0] in_pc_s, in_data_s;

    if (g == 0) begin : g_head
      assign in_v_s    = accept_s;
      assign in_pc_s   = req_pc;
      assign in_data_s = ld_data_s;
      assign in_adel_s = exc_adel_s;
      assign in_ades_s = exc_ades_s;
    end else begin : g_tail
      assign in_v_s    = v_s[g-1];
      assign in_pc_s   = pc_s[g-1];
      assign in_data_s = data_s[g-1];
      assign in_adel_s = adel_v_s[g-1];
      assign in_ades_s = ades_v_s[g-1];
    end

    // A stage may load when the output drains or any stage at or after it is empty
    assign en_s[g] = resp_ready || !(&v_s[LATENCY-1:g]);

    // Stage register: holds on stall, flush drops only the valid bit
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_r    <= 1'b0;
        pc_r   <= 32'h0000_0000;
        data_r <= 32'h0000_0000;
        adel_r <= 1'b0;
        ades_r <= 1'b0;
      end else begin
        if (flush) begin
          v_r <= 1'b0;
        end else if (en_s[g]) begin
          v_r <= in_v_s;
        end
        if (en_s[g]) begin
          pc_r   <= in_pc_s;
          data_r <= in_data_s;
          adel_r <= in_adel_s;
          ades_r <= in_ades_s;
        end
      end
    end

    assign v_s[g]      = v_r;
    assign pc_s[g]     = pc_r;
    assign data_s[g]   = data_r;
    assign adel_v_s[g] = adel_r;
    assign ades_v_s[g] = ades_r;
  end

  assign resp_valid = v_s[LATENCY-1];
  assign resp_rdata = data_s[LATENCY-1];
  assign resp_pc    = pc_s[LATENCY-1];
  assign resp_adel  = adel_v_s[LATENCY-1];
  assign resp_ades  = ades_v_s[LATENCY-1];

endmodule
